// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared op/state enums and constants for the RV32M multiply/divide sequencer
package rv32m_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;
  localparam int          ITERS         = 32;
endpackage

// File: rtl/rv32m_muldiv_ctrl_if.sv
// rv32m_muldiv_ctrl_if: EX-stage request/result bundle for the RV32M sequencer
interface rv32m_muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             i_valid;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_rs1_data;
  logic [WIDTH-1:0] i_rs2_data;
  logic             i_flush;
  logic             o_ready;
  logic             o_stall;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  modport slave (input i_valid, i_op, i_rs1_data, i_rs2_data, i_flush,
                 output o_ready, o_stall, o_valid, o_result);
  modport master (output i_valid, i_op, i_rs1_data, i_rs2_data, i_flush,
                  input o_ready, o_stall, o_valid, o_result);
endinterface

// File: rtl/rv32m_muldiv_datapath.sv
// rv32m_muldiv_datapath: magnitude shift-add/shift-subtract engine with sign fix-up (RV32M_FAST_MUL_EN: one-shot multiply)
module rv32m_muldiv_datapath
  import rv32m_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        step_i,
  input  op_e         op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] res_o
);
  logic [63:0] acc_q, acc_d, mul_init, prod;
  logic [31:0] b_q, b_d, m1, m2;
  op_e         op_q, op_d;
  logic        neg_q, neg_d, n1, n2;
  logic [32:0] sum, rem_s, sub;
  assign n1 = rs1_i[31] && (op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM);
  assign n2 = rs2_i[31] && (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
  assign m1 = n1 ? -rs1_i : rs1_i;
  assign m2 = n2 ? -rs2_i : rs2_i;
`ifdef RV32M_FAST_MUL_EN
  assign mul_init = {32'b0, m1} * {32'b0, m2};
`else
  assign mul_init = {32'b0, m2};
`endif
  // one iteration: acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem_s = acc_q[63:31];
    sub   = rem_s - {1'b0, b_q};
    op_d  = start_i ? op_i : op_q;
    neg_d = start_i ? ((op_i[2] && op_i[1]) ? n1 : n1 ^ n2) : neg_q;
    b_d   = start_i ? (op_i[2] ? m2 : m1) : b_q;
    acc_d = start_i ? (op_i[2] ? {32'b0, m1} : mul_init)
          : !step_i ? acc_q
          : op_q[2] ? (sub[32] ? {rem_s[31:0], acc_q[30:0], 1'b0} : {sub[31:0], acc_q[30:0], 1'b1})
          : {sum, acc_q[31:1]};
    prod  = neg_d ? -acc_d : acc_d;
    res_o = !op_d[2] ? (op_d[1:0] == 2'b00 ? prod[31:0] : prod[63:32])
          : op_d[1] ? (neg_d ? -acc_d[63:32] : acc_d[63:32])
          : (neg_d ? -acc_d[31:0] : acc_d[31:0]);
  end
  // operand, sign and accumulator state
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      op_q  <= OP_MUL;
      neg_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      op_q  <= op_d;
      neg_q <= neg_d;
    end
  end
endmodule

// File: rtl/rv32m_muldiv_ctrl.sv
// rv32m_muldiv_ctrl: RV32M multiply/divide sequencer with stall handshake (RV32M_FAST_MUL_EN: single-cycle multiply)
module rv32m_muldiv_ctrl
  import rv32m_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                  i_clk,
  input logic                  i_rst,
  rv32m_muldiv_ctrl_if.slave   bus
);
  state_e           state_q;
  logic [4:0]       cnt_q;
  logic             o_valid_q;
  logic [WIDTH-1:0] o_result_q;
  op_e              op;
  logic             accept, div_zero, ovf, early;
  logic [31:0]      early_res, dp_res;
  assign op       = op_e'(bus.i_op);
  assign accept   = bus.i_valid && state_q == S_IDLE && !bus.i_flush;
  assign div_zero = op[2] && bus.i_rs2_data == '0;
  assign ovf      = (op == OP_DIV || op == OP_REM) && bus.i_rs1_data == SIGNED_MIN && bus.i_rs2_data == '1;
`ifdef RV32M_FAST_MUL_EN
  assign early    = div_zero || ovf || !op[2];
`else
  assign early    = div_zero || ovf;
`endif
  assign early_res = div_zero ? (op[1] ? bus.i_rs1_data : DIV_ZERO_QUOT)
                   : ovf ? (op[1] ? 32'd0 : SIGNED_MIN) : dp_res;
  assign bus.o_ready  = state_q == S_IDLE;
  assign bus.o_stall  = (state_q == S_IDLE && bus.i_valid && !bus.i_flush) || state_q == S_BUSY;
  assign bus.o_valid  = o_valid_q;
  assign bus.o_result = o_result_q;
  rv32m_muldiv_datapath u_dp (
    .clk     (i_clk),
    .rst     (i_rst),
    .start_i (accept),
    .step_i  (state_q == S_BUSY),
    .op_i    (op),
    .rs1_i   (bus.i_rs1_data),
    .rs2_i   (bus.i_rs2_data),
    .res_o   (dp_res)
  );
  // IDLE -> BUSY/DONE on accept, 32 iterations in BUSY, one-cycle result pulse in DONE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
    end else begin
      o_valid_q <= 1'b0;
      if (bus.i_flush) state_q <= S_IDLE;
      else begin
        case (state_q)
          S_IDLE: if (bus.i_valid) begin
            cnt_q     <= 5'(ITERS - 1);
            state_q   <= early ? S_DONE : S_BUSY;
            o_valid_q <= early;
            if (early) o_result_q <= early_res;
          end
          S_BUSY: begin
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
              state_q    <= S_DONE;
              o_valid_q  <= 1'b1;
              o_result_q <= dp_res;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/rv32m_muldiv_ctrl.md
# rv32m_muldiv_ctrl

Sequencer for the RV32M multiply/divide resource in the EX stage. Accepts one M-extension operation at a time, runs an iterative shift-add / shift-subtract datapath, and holds the pipeline via a stall output until the result is ready. It sits beside the integer ALU. The EX-stage result mux selects this block's output when `o_valid` is high.

## Interface
- `WIDTH`, 32: operand and result width; only 32 is supported.
- `i_clk`  in  1  rising-edge clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  EX stage holds an M-extension instruction.
- `i_op`  in  3  funct3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- `i_rs1_data`  in  WIDTH  first operand (dividend / multiplicand).
- `i_rs2_data`  in  WIDTH  second operand (divisor / multiplier).
- `i_flush`  in  1  abort the current operation (branch mispredict or trap).
- `o_ready`  out  1  block is IDLE and can accept an operation.
- `o_stall`  out  1  pipeline stall request (combinational).
- `o_valid`  out  1  one-cycle pulse; `o_result` is valid.
- `o_result`  out  WIDTH  registered result.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Accept:** an operation is accepted when `i_valid && o_ready && !i_flush`. Operands and op are latched, and the 5-bit iteration counter is loaded with 31.
- **IDLE to DONE (next cycle):**
  - DIV/DIVU/REM/REMU with divisor 0.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF.
  - MUL* when `RV32M_FAST_MUL_EN` is defined.
- **IDLE to BUSY:** all other accepted operations.
- **BUSY:** one iteration per cycle, counter decrements. When the counter is 0, go to DONE.
- **DONE:** `o_result` is already registered and `o_valid` is 1. Next state is IDLE unconditionally.
- **Signed handling:**
  - Operands are converted to unsigned magnitudes per op signedness. MULHSU: rs1 signed, rs2 unsigned.
  - The final 64-bit product, quotient or remainder is negated when its sign rule requires it.
  - Quotient sign is rs1 XOR rs2. Remainder sign follows the dividend.
  - Magnitude of 0x80000000 is 2^31 and fits in 32 bits unsigned.
- **Result select:**
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- **Divide by zero:** quotient 0xFFFFFFFF (signed and unsigned); remainder = rs1.
- **Signed overflow:** quotient 0x80000000, remainder 0.
- **Stall:** `o_stall = (IDLE && i_valid && !i_flush) || BUSY`. It is low in DONE, so the instruction advances in the same cycle `o_valid` is high.
- **Flush:** from any state, the next state is IDLE. No `o_valid` is produced for the aborted operation. A flush in the same cycle as `i_valid` blocks acceptance. A flush during DONE does not suppress that cycle's `o_valid`; the downstream kill logic discards it.
- **Reset values:**
  - State IDLE, counter 0.
  - `o_valid` 0, `o_result` 0, `o_ready` 1.
  - `o_stall` 0 (while `i_valid` is low).
- **Reset mid-operation:** the operation is abandoned with no output pulse.

## Timing
- Cycle 0 is the accept cycle (`o_stall` = 1).
- **Iterative path:** BUSY for cycles 1–32, DONE in cycle 33 with `o_valid` = 1. `o_stall` is high for cycles 0–32. Total occupancy is 34 cycles.
- **Early-out path:** DONE in cycle 1. `o_stall` is high in cycle 0 only.
- **Back-to-back:** `o_ready` is low in DONE. The next operation is accepted at the earliest one cycle after DONE.
- **Stability:** `o_result` is held after DONE until the next DONE. No combinational path exists from `i_rs*` to `o_result`.

## Configuration
- **`RV32M_FAST_MUL_EN` defined:** MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit multiplier on the magnitudes, registered at the accept edge. They follow the early-out timing (DONE in cycle 1). Divides are unchanged.
- **`RV32M_FAST_MUL_EN` undefined:** multiplies use the 32-iteration shift-add datapath and share the counter and FSM with divide. Multiplies then have the iterative 33-cycle latency.

## Structure
- **Shared package `rv32m_pkg`:**
  - Op enum mirroring funct3.
  - FSM state enum.
  - `DIV_ZERO_QUOT` (0xFFFFFFFF).
  - `SIGNED_MIN` (0x80000000).
  - Iteration-count constant (32).
- **Sub-module `rv32m_muldiv_datapath`:**
  - Holds the 64-bit accumulator/remainder register, the shift-add / shift-subtract step and the sign fix-up.
  - Controlled by `start`, `step` and `op` strobes from this block's FSM and counter.

## Test plan
- DIVU 100 / 7, no flush → `o_valid` in cycle 33, `o_result` = 14. REMU with the same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1).
- DIV 5 / 0 → 0xFFFFFFFF in cycle 1. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1. REM with the same operands → 0.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Latency is 33 cycles without `RV32M_FAST_MUL_EN` and 1 cycle with it.
- Start DIVU, assert `i_flush` in cycle 10 → IDLE in cycle 11, `o_ready` = 1, no `o_valid`. Accept a new MUL 6 × 7 immediately → result 42.
- Assert `i_rst` in cycle 5 of an operation → cycle 6: `o_valid` = 0, `o_result` = 0, `o_ready` = 1, no later pulse.
